link_supervisor: RTL and testbench
==================================

LINK_SUPERVISOR -- requirements
Module: link_supervisor

Interface
REQ-001 Parameter LINK_TIMER, default 16 (8-bit, legal 1..255): consecutive cycles code_status must hold high before link_up asserts.
REQ-002 clk  input  1  single clock; all flops rise on posedge clk.
REQ-003 RESET  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-004 code_status  input  1  synchronizer lock indication; 1 = sync acquired.
REQ-005 tx_req  input  1  requester wants to send data code groups.
REQ-006 tx_data_cg  input  10  data code group from requester, sampled when tx_grant=1.
REQ-007 tx_grant  output  1  combinational; tx_data_cg is consumed at this clock edge.
REQ-008 tx_code_group  output  10  registered transmit code group.
REQ-009 link_up  output  1  registered; link qualified.
REQ-010 sync_loss_cnt  output  8  registered count of link-up to link-down transitions.

Function
REQ-011 Code-group constants: K28.5=1100000101, D16.2=1001000101, K27.7 (start)=1101101000, K29.7 (end)=1011101000.
REQ-012 FSM states: LINK_DOWN, LINK_WAIT, UP_IDLE, UP_DATA; one-hot encoding.
REQ-013 Idle generator: 1-bit phase toggles every cycle in LINK_DOWN, LINK_WAIT, UP_IDLE; phase 0 emits K28.5, phase 1 emits D16.2.
REQ-014 LINK_DOWN: code_status=1 -> LINK_WAIT, timer loaded to 1; else stay.
REQ-015 LINK_WAIT: code_status=0 -> LINK_DOWN, timer cleared, no counter change; code_status=1 and timer==LINK_TIMER -> UP_IDLE; else timer+1.
REQ-016 link_up=1 exactly when state is UP_IDLE or UP_DATA, updated on the same edge as state.
REQ-017 UP_IDLE: tx_req=1 and phase=0 (about to emit K28.5) -> emit K27.7 instead, go UP_DATA; tx_req=1 with phase=1 waits one cycle (ordered set never split).
REQ-018 UP_DATA: tx_grant = tx_req & code_status; when tx_grant=1, tx_code_group <= tx_data_cg next cycle (1-cycle latency).
REQ-019 UP_DATA with tx_req=0: emit K29.7, go UP_IDLE with phase forced to 0.
REQ-020 tx_grant=0 in every state other than UP_DATA.
REQ-021 code_status=0 in UP_IDLE or UP_DATA has priority over all else: next state LINK_DOWN, link_up<=0, phase forced to 0, tx_code_group<=K28.5, packet truncated without K29.7, sync_loss_cnt+1.
REQ-022 sync_loss_cnt saturates at 255; never wraps.
REQ-023 tx_req and code_status drop in same cycle in UP_DATA: REQ-021 applies (K28.5, not K29.7).

Reset
REQ-024 RESET=1 at an edge: state LINK_DOWN, phase 0, timer 0, link_up 0, tx_code_group K28.5, sync_loss_cnt 0; overrides all inputs.
REQ-025 RESET mid-packet truncates immediately; sync_loss_cnt is cleared, not incremented.
REQ-026 First cycle after RESET deasserts: tx_code_group=K28.5 then D16.2 alternation.

Configuration
REQ-027 Macro LINK_STATS_EN defined: sync_loss_cnt implemented per REQ-010/021/022.
REQ-028 LINK_STATS_EN undefined: no counter flops; sync_loss_cnt drives constant 8'h00; all other behaviour identical.

Verification
REQ-029 RESET 3 cycles, code_status=0 -> tx_code_group alternates 1100000101/1001000101, link_up=0, tx_grant=0.
REQ-030 code_status=1 held, LINK_TIMER=16 -> link_up rises exactly 17 edges after code_status first sampled high; drop at cycle 10 of wait -> no link_up, sync_loss_cnt unchanged.
REQ-031 Link up, tx_req=1 for 4 words 0x0F0..0x0F3 requested on phase 1 -> one idle wait, K27.7, 4 data words in order, K29.7, then K28.5.
REQ-032 code_status=0 during word 2 of a packet -> next tx_code_group=K28.5, link_up=0, tx_grant=0 same cycle, sync_loss_cnt 0->1.
REQ-033 300 link up/down cycles with LINK_STATS_EN -> sync_loss_cnt=255; without macro -> 0.
REQ-034 RESET asserted in UP_DATA -> next cycle all outputs at REQ-024 values.

Source files
------------

// File: rtl/link_supervisor.sv
// Link supervisor: qualifies the link from code_status, generates K28.5/D16.2 idles and frames packets with K27.7/K29.7.
// Build option: define LINK_STATS_EN to implement the sync-loss counter; otherwise sync_loss_cnt is tied to zero.
module link_supervisor #(
    parameter logic [7:0] LINK_TIMER = 8'd16
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       code_status,
    input  logic       tx_req,
    input  logic [9:0] tx_data_cg,
    output logic       tx_grant,
    output logic [9:0] tx_code_group,
    output logic       link_up,
    output logic [7:0] sync_loss_cnt
);

    localparam logic [9:0] K28_5 = 10'b1100000101;
    localparam logic [9:0] D16_2 = 10'b1001000101;
    localparam logic [9:0] K27_7 = 10'b1101101000;
    localparam logic [9:0] K29_7 = 10'b1011101000;

    localparam int LINK_DOWN_B = 0;
    localparam int LINK_WAIT_B = 1;
    localparam int UP_IDLE_B   = 2;
    localparam int UP_DATA_B   = 3;

    localparam logic [3:0] S_LINK_DOWN = 4'b0001;
    localparam logic [3:0] S_LINK_WAIT = 4'b0010;
    localparam logic [3:0] S_UP_IDLE   = 4'b0100;
    localparam logic [3:0] S_UP_DATA   = 4'b1000;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       phase;
    logic       phase_nxt;
    logic [7:0] timer;
    logic [7:0] timer_nxt;
    logic [9:0] tx_cg_nxt;

    always_ff @(posedge clk) begin
        if (RESET) begin
            state <= S_LINK_DOWN;
        end else begin
            state <= state_nxt;
        end
    end

    // Loss of sync in either up state wins over any transmit request.
    always_comb begin
        state_nxt = state;
        case (state)
            S_LINK_DOWN: begin
                if (code_status) state_nxt = S_LINK_WAIT;
            end
            S_LINK_WAIT: begin
                if (!code_status)             state_nxt = S_LINK_DOWN;
                else if (timer == LINK_TIMER) state_nxt = S_UP_IDLE;
            end
            S_UP_IDLE: begin
                if (!code_status)          state_nxt = S_LINK_DOWN;
                else if (tx_req && !phase) state_nxt = S_UP_DATA;
            end
            S_UP_DATA: begin
                if (!code_status) state_nxt = S_LINK_DOWN;
                else if (!tx_req) state_nxt = S_UP_IDLE;
            end
            default: state_nxt = S_LINK_DOWN;
        endcase
    end

    // phase names the idle symbol emitted at the next edge: 0 -> K28.5, 1 -> D16.2.
    always_comb begin
        tx_grant  = 1'b0;
        tx_cg_nxt = phase ? D16_2 : K28_5;
        phase_nxt = ~phase;
        timer_nxt = timer;
        case (state)
            S_LINK_DOWN: begin
                timer_nxt = code_status ? 8'd1 : 8'd0;
            end
            S_LINK_WAIT: begin
                if (!code_status || timer == LINK_TIMER) timer_nxt = 8'd0;
                else                                     timer_nxt = timer + 8'd1;
            end
            S_UP_IDLE: begin
                if (!code_status) begin
                    tx_cg_nxt = K28_5;
                    phase_nxt = 1'b0;
                end else if (tx_req && !phase) begin
                    tx_cg_nxt = K27_7;
                end
            end
            S_UP_DATA: begin
                tx_grant  = tx_req & code_status;
                phase_nxt = phase;
                if (!code_status) begin
                    tx_cg_nxt = K28_5;
                    phase_nxt = 1'b0;
                end else if (tx_req) begin
                    tx_cg_nxt = tx_data_cg;
                end else begin
                    tx_cg_nxt = K29_7;
                    phase_nxt = 1'b0;
                end
            end
            default: begin
                tx_cg_nxt = K28_5;
                phase_nxt = 1'b0;
                timer_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            phase         <= 1'b0;
            timer         <= 8'd0;
            tx_code_group <= K28_5;
            link_up       <= 1'b0;
        end else begin
            phase         <= phase_nxt;
            timer         <= timer_nxt;
            tx_code_group <= tx_cg_nxt;
            link_up       <= state_nxt[UP_IDLE_B] | state_nxt[UP_DATA_B];
        end
    end

`ifdef LINK_STATS_EN
    logic       loss_evt;
    logic [7:0] loss_cnt;

    assign loss_evt = (state[UP_IDLE_B] | state[UP_DATA_B]) & ~code_status;

    // Saturating count of up-to-down transitions; reset clears rather than counts.
    always_ff @(posedge clk) begin
        if (RESET) begin
            loss_cnt <= 8'd0;
        end else if (loss_evt && loss_cnt != 8'hFF) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end

    assign sync_loss_cnt = loss_cnt;
`else
    assign sync_loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_link_supervisor.sv
// Bench for link_supervisor: a cycle model pushes expected outputs per driven cycle, popped after the edge.
`timescale 1ns/1ps
module tb_link_supervisor;

    localparam logic [9:0] K28_5 = 10'b1100000101;
    localparam logic [9:0] D16_2 = 10'b1001000101;
    localparam logic [9:0] K27_7 = 10'b1101101000;
    localparam logic [9:0] K29_7 = 10'b1011101000;
    localparam int LT = 16;
`ifdef LINK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       req;
    logic [9:0] data;
    logic       grant;
    logic [9:0] cg;
    logic       up;
    logic [7:0] cnt;

    always #5 clk = ~clk;

    link_supervisor #(.LINK_TIMER(8'd16)) dut (
        .clk          (clk),
        .RESET        (rst),
        .code_status  (cs),
        .tx_req       (req),
        .tx_data_cg   (data),
        .tx_grant     (grant),
        .tx_code_group(cg),
        .link_up      (up),
        .sync_loss_cnt(cnt)
    );

    typedef struct packed {
        logic [9:0] cg;
        logic       up;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    logic [9:0] seen[$];
    bit         capture = 1'b0;
    logic       obs_grant;
    logic       exp_grant;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: 0 down, 1 wait, 2 up idle, 3 up data
    int         m_st = 0;
    logic       m_ph = 1'b0;
    int         m_tmr = 0;
    logic [9:0] m_cg = K28_5;
    int         m_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic c, input logic q, input logic [9:0] d);
        if (r) begin
            m_st = 0; m_ph = 1'b0; m_tmr = 0; m_cg = K28_5; m_cnt = 0;
        end else if (m_st >= 2 && !c) begin
            m_st = 0; m_ph = 1'b0; m_cg = K28_5;
            if (STATS && m_cnt < 255) m_cnt++;
        end else if (m_st == 3) begin
            if (q) m_cg = d;
            else begin m_cg = K29_7; m_ph = 1'b0; m_st = 2; end
        end else if (m_st == 2 && q && !m_ph) begin
            m_cg = K27_7; m_st = 3;
        end else begin
            m_cg = m_ph ? D16_2 : K28_5;
            m_ph = ~m_ph;
            if (m_st == 0 && c) begin
                m_st = 1; m_tmr = 1;
            end else if (m_st == 1) begin
                if (!c)              begin m_st = 0; m_tmr = 0; end
                else if (m_tmr == LT) m_st = 2;
                else                 m_tmr++;
            end
        end
    endtask

    task automatic step(input logic r, input logic c, input logic q, input logic [9:0] d);
        exp_t e;
        @(negedge clk);
        rst = r; cs = c; req = q; data = d;
        exp_grant = (m_st == 3) && q && c;
        #1;
        obs_grant = grant;
        check_eq("tx_grant", grant, exp_grant);
        model_step(r, c, q, d);
        e.cg  = m_cg;
        e.up  = (m_st >= 2);
        e.cnt = m_cnt[7:0];
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("tx_code_group", cg, e.cg);
        check_eq("link_up", up, e.up);
        check_eq("sync_loss_cnt", cnt, e.cnt);
        if (capture) seen.push_back(cg);
    endtask

    task automatic bring_up();
        for (int k = 0; k < 40 && !up; k++) step(1'b0, 1'b1, 1'b0, 10'h000);
        check_eq("link_up_timeout", up, 1);
    endtask

    task automatic align_phase();
        for (int k = 0; k < 4 && cg !== K28_5; k++) step(1'b0, 1'b1, 1'b0, 10'h000);
        check_eq("phase_align", cg, K28_5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_pkt[8];
        int idx;
        int rise;
        rst = 1'b1; cs = 1'b0; req = 1'b0; data = 10'h000;

        // reset and idle alternation with no sync
        repeat (3) step(1'b1, 1'b0, 1'b0, 10'h000);
        check_eq("rst_cg", cg, K28_5);
        check_eq("rst_up", up, 0);
        check_eq("rst_cnt", cnt, 0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b1, 10'h0AA);
            check_eq("idle_alt", cg, (i % 2 == 0) ? K28_5 : D16_2);
            check_eq("idle_grant", obs_grant, 0);
        end

        // sync dropped on the 11th cycle of qualification
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 1'b0, 10'h000);
            check_eq("wait_no_up", up, 0);
        end
        step(1'b0, 1'b0, 1'b0, 10'h000);
        check_eq("wait_drop_up", up, 0);
        check_eq("wait_drop_cnt", cnt, 0);
        step(1'b0, 1'b0, 1'b0, 10'h000);

        // qualification latency
        rise = 0;
        for (int k = 1; k <= 40 && rise == 0; k++) begin
            step(1'b0, 1'b1, 1'b0, 10'h000);
            if (up) rise = k;
        end
        check_eq("link_up_edges", rise, 17);

        // four-word packet requested while D16.2 is due
        align_phase();
        exp_pkt = '{D16_2, K27_7, 10'h0F0, 10'h0F1, 10'h0F2, 10'h0F3, K29_7, K28_5};
        capture = 1'b1;
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, (idx < 4), 10'(10'h0F0 + idx));
            if (exp_grant) idx++;
        end
        capture = 1'b0;
        check_eq("pkt_len", seen.size(), 8);
        for (int i = 0; i < 8 && i < seen.size(); i++)
            check_eq($sformatf("pkt_cg%0d", i), seen[i], exp_pkt[i]);

        // sync lost during the second data word
        align_phase();
        step(1'b0, 1'b1, 1'b1, 10'h0F0);
        step(1'b0, 1'b1, 1'b1, 10'h0F0);
        check_eq("drop_sop", cg, K27_7);
        step(1'b0, 1'b1, 1'b1, 10'h0F0);
        check_eq("drop_w1", cg, 10'h0F0);
        check_eq("drop_cnt_before", cnt, 0);
        step(1'b0, 1'b0, 1'b1, 10'h0F1);
        check_eq("drop_grant", obs_grant, 0);
        check_eq("drop_cg", cg, K28_5);
        check_eq("drop_up", up, 0);
        check_eq("drop_cnt_after", cnt, STATS ? 1 : 0);

        // reset in the middle of a packet
        bring_up();
        for (int k = 0; k < 4 && m_st != 3; k++) step(1'b0, 1'b1, 1'b1, 10'h155);
        step(1'b0, 1'b1, 1'b1, 10'h2AA);
        check_eq("mid_pkt_data", cg, 10'h2AA);
        step(1'b1, 1'b1, 1'b1, 10'h3FF);
        check_eq("rst_pkt_cg", cg, K28_5);
        check_eq("rst_pkt_up", up, 0);
        check_eq("rst_pkt_cnt", cnt, 0);
        step(1'b0, 1'b1, 1'b1, 10'h3FF);
        check_eq("post_rst_grant", obs_grant, 0);
        check_eq("post_rst_cg0", cg, K28_5);
        step(1'b0, 1'b1, 1'b1, 10'h3FF);
        check_eq("post_rst_cg1", cg, D16_2);

        // random traffic with occasional sync loss
        for (int k = 0; k < 600; k++)
            step(1'b0, ($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)), 10'($urandom));

        // counter saturation over many up/down cycles
        step(1'b1, 1'b0, 1'b0, 10'h000);
        for (int n = 0; n < 300; n++) begin
            bring_up();
            step(1'b0, 1'b0, 1'b0, 10'h000);
        end
        check_eq("cnt_saturate", cnt, STATS ? 255 : 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
